// File: rtl/npcnn_pkg.sv
// Shared widths, FSM state type and max helpers for the npcnn pooling stage.
package npcnn_pkg;

  localparam int DATA_W = 20;
  localparam int ACT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] max_s(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/npcnn_linebuf.sv
// Register-based line buffer holding one partial pooled row (even-row pair maxima).
module npcnn_linebuf #(
  parameter int depth = 2,
  parameter int width = 20,
  localparam int AW   = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [width-1:0] rdata
);

  // No reset: every entry is written on the even row before the odd row reads it.
  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/npcnn_maxpool.sv
// 2x2 max-pool with ReLU and saturating requantisation over a raster-order o_size x o_size map.
module npcnn_maxpool
  import npcnn_pkg::*;
#(
  parameter int o_size = 4,
  parameter int shift  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [ACT_W-1:0]  dout,
  output logic              dout_valid,
  output logic              frame_done,
  output logic              busy,
  output state_t            fsm_state
);

  localparam int HALF = o_size / 2;
  localparam int CW   = (o_size > 2) ? $clog2(o_size) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'((1 << ACT_W) - 1);

  generate
    if ((o_size % 2) != 0 || o_size < 2) begin : g_bad_size
      $error("npcnn_maxpool: o_size must be even and at least 2");
    end
  endgenerate

  state_t state, state_nx;
  logic [CW-1:0] row, col, col_half;
  logic [DATA_W-1:0] h, r, lb_rdata, pooled, q;
  logic accept, last_px, win, lb_we;
  logic [AW-1:0] lb_addr;

  assign accept   = (state == RUN) && din_valid;
  assign last_px  = (row == CW'(o_size - 1)) && (col == CW'(o_size - 1));
  assign r        = din[DATA_W-1] ? '0 : din;
  assign col_half = col >> 1;
  assign lb_addr  = col_half[AW-1:0];
  assign lb_we    = accept && !row[0] && col[0];
  assign win      = accept && row[0] && col[0];
  assign pooled   = max_u(h, r);
  assign q        = pooled >> shift;
  assign busy      = (state == RUN);
  assign fsm_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && last_px) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Counters and hold register; a start in IDLE clears position, start in RUN is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
      h   <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == CW'(o_size - 1)) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
      if (!col[0]) h <= row[0] ? max_u(lb_rdata, r) : r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= win;
      frame_done <= win && last_px;
      if (win) dout <= (q > SAT_MAX) ? SAT_MAX[ACT_W-1:0] : q[ACT_W-1:0];
    end
  end

  npcnn_linebuf #(
    .depth(HALF),
    .width(DATA_W)
  ) u_linebuf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(pooled),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

endmodule

// File: tb/tb_npcnn_maxpool.sv
// Directed + randomized bench for npcnn_maxpool (o_size=4, shift=4) against a pooled-map model.
module tb_npcnn_maxpool;
  import npcnn_pkg::*;

  localparam int N     = 4;
  localparam int SHIFT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic [ACT_W-1:0]  dout;
  logic              dout_valid;
  logic              frame_done;
  logic              busy;
  state_t            fsm_state;

  npcnn_maxpool #(.o_size(N), .shift(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .frame_done(frame_done),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [ACT_W-1:0]  exp_q[$];
  logic [ACT_W-1:0]  last_dout;
  logic [DATA_W-1:0] frame [N*N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: pooled map from plain integer arithmetic over the stored frame.
  task automatic build_expected();
    for (int pr = 0; pr < N/2; pr++) begin
      for (int pc = 0; pc < N/2; pc++) begin
        int m = 0;
        int qv;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            int v = int'($signed(frame[(2*pr+dr)*N + 2*pc+dc]));
            if (v > m) m = v;
          end
        end
        qv = m / (1 << SHIFT);
        if (qv > 255) qv = 255;
        exp_q.push_back(ACT_W'(qv));
      end
    end
  endtask

  task automatic step(input logic st, input logic v, input logic [DATA_W-1:0] d,
                      input logic exp_dv, input logic exp_fd, input logic exp_busy);
    start = st;
    din_valid = v;
    din = d;
    @(posedge clk);
    @(negedge clk);
    chk("dout_valid", dout_valid, exp_dv);
    chk("frame_done", frame_done, exp_fd);
    chk("busy", busy, exp_busy);
    if (exp_dv) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 1, 0);
      end else begin
        last_dout = exp_q.pop_front();
        chk("dout", dout, last_dout);
      end
    end else begin
      chk("dout_hold", dout, last_dout);
    end
  endtask

  task automatic do_start();
    step(1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input int npix, input int gmin, input int gmax, input logic gap_start);
    build_expected();
    for (int k = 0; k < npix; k++) begin
      int row = k / N;
      int col = k % N;
      logic win, lastp;
      if (k > 0 && gmax > 0) begin
        int g = $urandom_range(gmax, gmin);
        for (int i = 0; i < g; i++)
          step(gap_start ? 1'($urandom_range(1, 0)) : 1'b0, 1'b0, DATA_W'($urandom),
               1'b0, 1'b0, 1'b1);
      end
      win   = (row % 2 == 1) && (col % 2 == 1);
      lastp = (k == N*N - 1);
      step(1'b0, 1'b1, frame[k], win, win && lastp, !lastp);
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N*N; k++) frame[k] = DATA_W'(16 * k);
  endtask

  task automatic fill_const(input logic [DATA_W-1:0] v);
    for (int k = 0; k < N*N; k++) frame[k] = v;
  endtask

  initial begin
    last_dout = '0;
    reset = 1'b0;
    start = 1'b0;
    din_valid = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // din_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);

    // Start with din_valid high, then ramp frame -> 5, 7, 13, 15
    do_start();
    fill_ramp();
    send_frame(N*N, 0, 0, 1'b0);
    chk("ramp_q_drained", exp_q.size(), 0);

    // Back-to-back start, same frame with 1..3 cycle gaps and start pulses in gaps
    do_start();
    send_frame(N*N, 1, 3, 1'b1);

    do_start();
    fill_const(-20'sd100);
    send_frame(N*N, 0, 2, 1'b0);

    do_start();
    fill_const(20'h7FFFF);
    send_frame(N*N, 0, 0, 1'b0);

    // Saturation boundary windows plus random filler
    for (int k = 0; k < N*N; k++) frame[k] = DATA_W'($urandom_range(20'h01FFF, 0));
    for (int k = 0; k < N*N; k++) if ($urandom_range(1, 0) == 1) frame[k] = -frame[k];
    foreach (frame[k]) begin
      if ((k / N) < 2 && (k % N) < 2) frame[k] = 20'h00FF0;
      else if ((k / N) < 2) frame[k] = 20'h00FE0;
    end
    do_start();
    send_frame(N*N, 0, 1, 1'b0);

    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N*N; k++) frame[k] = DATA_W'($urandom);
      do_start();
      send_frame(N*N, 0, 3, 1'b1);
    end

    // Reset mid-frame after 6 pixels discards the partial frame
    do_start();
    fill_ramp();
    send_frame(6, 0, 0, 1'b0);
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_busy", busy, 0);
    last_dout = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
    do_start();
    send_frame(N*N, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
    chk("final_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
